seq_generator: RTL and testbench

- Serial pattern transmitter: the source side of the serial bit stream consumed by seq_detector.
- Holds a WIDTH-bit pattern register and shifts it out MSB-first on d, one bit per clock.
- Repeats the pattern a programmable number of times, back-to-back.
- Used as the stimulus/source block that drives a detector's d input in-system and in silicon bring-up.

---
 rtl/seq_generator.sv | 150 +++++++++++++++
 tb/tb_seq_generator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first on d,
// repeating it repeat_n times back-to-back, with registered d/valid/busy/done.
module seq_generator #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b0111,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             d,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             d_q, d_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] start_pat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= PATTERN;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      d_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      d_q       <= d_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    d_d       = d_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start_pat = load ? pattern_in : pattern_q;

    unique case (state_q)
      IDLE: begin
        d_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (load) begin
          pattern_d = pattern_in;
        end
        if (start) begin
          busy_d = 1'b1;
          if (repeat_n != '0) begin
            state_d   = SHIFT;
            shreg_d   = start_pat;
            bit_cnt_d = LAST_BIT;
            rep_cnt_d = repeat_n;
            d_d       = start_pat[WIDTH-1];
            valid_d   = 1'b1;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
      end

      SHIFT: begin
        // The shift register rotates, so after WIDTH steps it holds the
        // original pattern again and the next repetition needs no reload.
        if (abort) begin
          state_d   = IDLE;
          d_d       = 1'b0;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          rep_cnt_d = '0;
          bit_cnt_d = '0;
        end else if (bit_cnt_q != '0) begin
          shreg_d   = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
          d_d       = shreg_q[WIDTH-2];
          bit_cnt_d = bit_cnt_q - 1'b1;
        end else if (rep_cnt_q > CNT_W'(1)) begin
          shreg_d   = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
          d_d       = shreg_q[WIDTH-2];
          bit_cnt_d = LAST_BIT;
          rep_cnt_d = rep_cnt_q - 1'b1;
        end else begin
          state_d   = FINISH;
          d_d       = 1'b0;
          valid_d   = 1'b0;
          done_d    = 1'b1;
          rep_cnt_d = '0;
        end
      end

      FINISH: begin
        state_d = IDLE;
        d_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        d_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign d     = d_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: streams are checked bit by bit against
// hand-written patterns, including abort, load-while-busy and async reset.
module tb_seq_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [3:0] patternIn = 4'b0000;
  logic       start = 1'b0;
  logic [7:0] repeatN = 8'd0;
  logic       abort = 1'b0;
  logic       d, valid, busy, done;

  int checks = 0;
  int failures = 0;

  seq_generator dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .pattern_in(patternIn),
    .start(start),
    .repeat_n(repeatN),
    .abort(abort),
    .d(d),
    .valid(valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of control inputs, wait for the edge that samples them,
  // then return the one-shot controls to zero.
  task automatic applyStimulus(input logic ld, input logic [3:0] pat, input logic st,
                               input logic [7:0] reps);
    load = ld;
    patternIn = pat;
    start = st;
    repeatN = reps;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_d"}, 32'(d), 32'd0);
    checkOutput({tag, "_valid"}, 32'(valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Checks a whole transmission starting at the negedge after start was
  // sampled. abortAt / loadAt pick a bit index at which abort, or a
  // load+start pair that must be ignored, is driven (-1 for none).
  task automatic expectStream(input string tag, input logic [3:0] pat, input int reps,
                              input int abortAt, input int loadAt);
    int n;
    n = 4 * reps;
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_d"}, 32'(d), 32'(pat[3 - (i % 4)]));
      checkOutput({tag, "_valid"}, 32'(valid), 32'd1);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      if (i == loadAt) begin
        load = 1'b1;
        patternIn = 4'b0001;
        start = 1'b1;
        repeatN = 8'd5;
      end
      if (i == abortAt) abort = 1'b1;
      @(negedge clk);
      load = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      if (i == abortAt) begin
        checkIdle({tag, "_abort"});
        return;
      end
    end
    checkOutput({tag, "_fin_d"}, 32'(d), 32'd0);
    checkOutput({tag, "_fin_valid"}, 32'(valid), 32'd0);
    checkOutput({tag, "_fin_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_fin_done"}, 32'(done), 32'd1);
    @(negedge clk);
    checkIdle({tag, "_after"});
  endtask

  initial begin
    $display("[TB] seq_generator bench start");
    reset = 1'b1;
    #12;
    checkIdle("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("post_reset");

    applyStimulus(1'b0, 4'b0000, 1'b1, 8'd1);
    expectStream("rep1", 4'b0111, 1, -1, -1);

    applyStimulus(1'b0, 4'b0000, 1'b1, 8'd3);
    expectStream("rep3", 4'b0111, 3, -1, -1);

    applyStimulus(1'b0, 4'b0000, 1'b1, 8'd255);
    expectStream("rep255", 4'b0111, 255, -1, -1);

    applyStimulus(1'b0, 4'b0000, 1'b1, 8'd0);
    checkOutput("rep0_valid", 32'(valid), 32'd0);
    checkOutput("rep0_busy", 32'(busy), 32'd1);
    checkOutput("rep0_done", 32'(done), 32'd1);
    checkOutput("rep0_d", 32'(d), 32'd0);
    @(negedge clk);
    checkIdle("rep0_after");

    applyStimulus(1'b0, 4'b0000, 1'b1, 8'd2);
    expectStream("abort", 4'b0111, 2, 1, -1);
    @(negedge clk);
    checkIdle("abort_nodone");
    applyStimulus(1'b0, 4'b0000, 1'b1, 8'd1);
    expectStream("post_abort", 4'b0111, 1, -1, -1);

    applyStimulus(1'b1, 4'b1010, 1'b0, 8'd0);
    checkIdle("load_idle");
    applyStimulus(1'b0, 4'b0000, 1'b1, 8'd2);
    expectStream("pat1010", 4'b1010, 2, -1, 2);
    applyStimulus(1'b0, 4'b0000, 1'b1, 8'd1);
    expectStream("pat1010_kept", 4'b1010, 1, -1, -1);

    applyStimulus(1'b1, 4'b1100, 1'b1, 8'd3);
    checkOutput("ldst_bit3", 32'(d), 32'd1);
    checkOutput("ldst_valid", 32'(valid), 32'd1);
    @(negedge clk);
    checkOutput("ldst_bit2", 32'(d), 32'd1);
    @(negedge clk);
    checkOutput("ldst_bit1", 32'(d), 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_d", 32'(d), 32'd0);
    checkOutput("async_valid", 32'(valid), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("reset_idle");
    applyStimulus(1'b0, 4'b0000, 1'b1, 8'd1);
    expectStream("post_reset_pat", 4'b0111, 1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
